// File: rtl/ssvga_pkg.sv
// Shared constants, FSM state type and byte-lane merge helper for the SSVGA dual-port RAM.
package ssvga_pkg;

   localparam int RDW_WRITE_FIRST = 0;
   localparam int RDW_READ_FIRST  = 1;
   localparam int RDW_NO_CHANGE   = 2;

   // Widest word the merge helper handles; callers zero-extend and truncate around it.
   localparam int MAX_DW = 256;
   localparam int MAX_BE = MAX_DW / 8;

   typedef enum logic {INIT, RUN} state_t;

   function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                    input logic [MAX_DW-1:0] new_w,
                                                    input logic [MAX_BE-1:0] be);
      logic [MAX_DW-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_BE; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/ssvga_dpram_port.sv
// Per-port read path: read-during-write selection, optional output register and valid pipeline.
module ssvga_dpram_port
   import ssvga_pkg::*;
#(
   parameter int DW       = 16,
   parameter int RDW_MODE = 0,
   parameter int OUT_REG  = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          acc,
   input  logic          we,
   input  logic [DW-1:0] rdata,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] dout,
   output logic          vld
);

   logic [DW-1:0] sel_p0;
   logic          vld_p0;
   logic [DW-1:0] do_p1;
   logic          vld_p1;

   // Stage 0: rdata is the pre-write word, wdata the merged word this port is writing.
   always_comb begin
      vld_p0 = acc && !(we && (RDW_MODE == RDW_NO_CHANGE));
      sel_p0 = (we && (RDW_MODE == RDW_WRITE_FIRST)) ? wdata : rdata;
   end

   // Stage 1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         do_p1  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) do_p1 <= sel_p0;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DW-1:0] do_p2;
         logic          vld_p2;

         // Stage 2
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               do_p2  <= '0;
               vld_p2 <= 1'b0;
            end else begin
               vld_p2 <= vld_p1;
               if (vld_p1) do_p2 <= do_p1;
            end
         end

         assign dout = do_p2;
         assign vld  = vld_p2;
      end else begin : g_no_reg
         assign dout = do_p1;
         assign vld  = vld_p1;
      end
   endgenerate

endmodule

// File: rtl/ssvga_dpram_param.sv
// Single-clock true-dual-port RAM with byte enables, A-priority collisions and a zero-init sequencer.
module ssvga_dpram_param
   import ssvga_pkg::*;
#(
   parameter int            DW       = 16,
   parameter int            AW       = 8,
   parameter int            RDW_MODE = 0,
   parameter int            OUT_REG  = 0,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   addra,
   input  logic [DW-1:0]   dia,
   input  logic [DW/8-1:0] bea,
   input  logic            ena,
   input  logic            wea,
   output logic [DW-1:0]   doa,
   output logic            doa_vld,
   input  logic [AW-1:0]   addrb,
   input  logic [DW-1:0]   dib,
   input  logic [DW/8-1:0] beb,
   input  logic            enb,
   input  logic            web,
   output logic [DW-1:0]   dob,
   output logic            dob_vld,
   output logic            busy,
   output logic            coll
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0] mem [DEPTH];

   state_t        state, state_nxt;
   logic [AW-1:0] cnt;
   logic          run;

   logic          acc_a, acc_b, wr_a, wr_b, same;
   logic [DW-1:0] old_a, old_b, merged_a, merged_b, merged_ab;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == INIT) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      if ((state == INIT) && (cnt == {AW{1'b1}})) state_nxt = RUN;
   end

   always_comb begin
      busy = (state == INIT);
      run  = (state == RUN);
   end

   always_comb begin
      acc_a = run && ena;
      acc_b = run && enb;
      wr_a  = acc_a && wea;
      wr_b  = acc_b && web;
      same  = (addra == addrb);
      old_a = mem[addra];
      old_b = mem[addrb];
      merged_a  = DW'(byte_merge(MAX_DW'(old_a), MAX_DW'(dia), MAX_BE'(bea)));
      merged_b  = DW'(byte_merge(MAX_DW'(old_b), MAX_DW'(dib), MAX_BE'(beb)));
      // Same-address double write: B lanes first, A lanes on top.
      merged_ab = DW'(byte_merge(MAX_DW'(merged_b), MAX_DW'(dia), MAX_BE'(bea)));
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT) begin
            mem[cnt] <= INIT_VAL;
         end else begin
            if (wr_a) mem[addra] <= (wr_b && same) ? merged_ab : merged_a;
            if (wr_b && !(wr_a && same)) mem[addrb] <= merged_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) coll <= 1'b0;
      else        coll <= acc_a && acc_b && same && (wea || web);
   end

   ssvga_dpram_port #(.DW(DW), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_port_a (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (acc_a),
      .we    (wea),
      .rdata (old_a),
      .wdata (merged_a),
      .dout  (doa),
      .vld   (doa_vld)
   );

   ssvga_dpram_port #(.DW(DW), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) u_port_b (
      .clk   (clk),
      .rst_n (rst_n),
      .acc   (acc_b),
      .we    (web),
      .rdata (old_b),
      .wdata (merged_b),
      .dout  (dob),
      .vld   (dob_vld)
   );

endmodule

// File: tb/tb_ssvga_dpram_param.sv
// Directed bench for ssvga_dpram_param: four instances (RDW modes 0/1/2, plus OUT_REG=1) share one stimulus.
module tb_ssvga_dpram_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addra, addrb;
   logic [15:0] dia, dib;
   logic [1:0]  bea, beb;
   logic        ena, enb, wea, web;

   logic [15:0] doa [4];
   logic [15:0] dob [4];
   logic        doa_vld [4];
   logic        dob_vld [4];
   logic        busy [4];
   logic        coll [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Instances 0..2: RDW_MODE 0..2 with OUT_REG=0; instance 3: WRITE_FIRST with OUT_REG=1.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      ssvga_dpram_param #(
         .DW(16), .AW(8), .RDW_MODE((g == 3) ? 0 : g), .OUT_REG((g == 3) ? 1 : 0), .INIT_VAL(16'h0000)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .addra(addra), .dia(dia), .bea(bea), .ena(ena), .wea(wea), .doa(doa[g]), .doa_vld(doa_vld[g]),
         .addrb(addrb), .dib(dib), .beb(beb), .enb(enb), .web(web), .dob(dob[g]), .dob_vld(dob_vld[g]),
         .busy(busy[g]), .coll(coll[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
      bea = 2'b11; beb = 2'b11;
   endtask

   task automatic wr_a(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
      ena = 1'b1; wea = 1'b1; addra = a; dia = d; bea = be;
   endtask

   task automatic rd_a(input logic [7:0] a);
      ena = 1'b1; wea = 1'b0; addra = a;
   endtask

   task automatic rd_b(input logic [7:0] a);
      enb = 1'b1; web = 1'b0; addrb = a;
   endtask

   task automatic count_busy(input string tag, input int exp_cycles);
      int n = 0;
      int v = 0;
      while (busy[0] && n < 400) begin
         n++;
         if (doa_vld[0] || dob_vld[0] || coll[0]) v++;
         step();
      end
      chk({tag, "_busy_cycles"}, n, exp_cycles);
      chk({tag, "_busy_inst3"}, busy[3], 1'b0);
      chk({tag, "_no_vld_in_init"}, v, 0);
   endtask

   initial begin
      logic [15:0] exp_d;
      rst_n = 1'b0; addra = '0; addrb = '0; dia = '0; dib = '0;
      idle();
      step();
      step();

      chk("rst_doa", doa[0], 16'h0);
      chk("rst_dob", dob[0], 16'h0);
      chk("rst_vld", {doa_vld[0], dob_vld[0], doa_vld[3], dob_vld[3]}, 4'b0);
      chk("rst_coll", coll[0], 1'b0);
      chk("rst_busy", {busy[0], busy[3]}, 2'b11);

      // Init runs with port A requesting reads; they must be ignored.
      rst_n = 1'b1;
      rd_a(8'h00);
      count_busy("init1", 256);

      // Read corners after init.
      rd_a(8'h00);
      rd_b(8'hFF);
      step();
      chk("t1_doa", doa[0], 16'h0000);
      chk("t1_doa_vld", doa_vld[0], 1'b1);
      chk("t1_dob", dob[0], 16'h0000);
      chk("t1_dob_vld", dob_vld[0], 1'b1);
      chk("t1_reg_vld_lat1", doa_vld[3], 1'b0);
      idle();
      step();
      chk("t1_vld_pulse", doa_vld[0], 1'b0);
      chk("t1_reg_vld_lat2", {doa_vld[3], dob_vld[3]}, 2'b11);
      step();
      chk("t1_reg_vld_pulse", doa_vld[3], 1'b0);

      // Byte-lane write.
      wr_a(8'h10, 16'hFFFF, 2'b11);
      step();
      wr_a(8'h10, 16'h12AB, 2'b01);
      step();
      idle();
      rd_b(8'h10);
      step();
      chk("t2_lane_merge", dob[0], 16'hFFAB);
      chk("t2_vld", dob_vld[0], 1'b1);

      // Double-write collisions.
      idle();
      wr_a(8'h20, 16'hAAAA, 2'b11);
      enb = 1'b1; web = 1'b1; addrb = 8'h20; dib = 16'h5555; beb = 2'b10;
      step();
      chk("t3_coll", coll[0], 1'b1);
      idle();
      rd_a(8'h20);
      step();
      chk("t3_coll_pulse", coll[0], 1'b0);
      chk("t3_a_wins", doa[0], 16'hAAAA);
      wr_a(8'h20, 16'hAAAA, 2'b01);
      enb = 1'b1; web = 1'b1; addrb = 8'h20; dib = 16'h5555; beb = 2'b10;
      step();
      chk("t3_coll2", coll[0], 1'b1);
      idle();
      rd_a(8'h20);
      step();
      chk("t3_split_lanes", doa[0], 16'h55AA);

      // Different addresses and same-address reads do not collide.
      idle();
      wr_a(8'h21, 16'h1111, 2'b11);
      enb = 1'b1; web = 1'b1; addrb = 8'h22; dib = 16'h2222; beb = 2'b11;
      step();
      chk("t3_no_coll_diff", coll[0], 1'b0);
      idle();
      rd_a(8'h21);
      rd_b(8'h22);
      step();
      chk("t3_no_coll_rr_addr", coll[0], 1'b0);
      chk("t3_wr21", doa[0], 16'h1111);
      chk("t3_wr22", dob[0], 16'h2222);
      idle();
      rd_a(8'h40);
      rd_b(8'h40);
      step();
      chk("t3_no_coll_rr", coll[0], 1'b0);

      // Read-during-write per mode, with B reading the same word.
      idle();
      rd_a(8'h20);
      step();
      wr_a(8'h30, 16'h00FF, 2'b11);
      step();
      wr_a(8'h30, 16'h1234, 2'b11);
      rd_b(8'h30);
      step();
      chk("t4_m0_doa", doa[0], 16'h1234);
      chk("t4_m0_vld", doa_vld[0], 1'b1);
      chk("t4_m1_doa", doa[1], 16'h00FF);
      chk("t4_m1_vld", doa_vld[1], 1'b1);
      chk("t4_m2_doa_held", doa[2], 16'h55AA);
      chk("t4_m2_vld", doa_vld[2], 1'b0);
      chk("t4_b_old", {dob[0], dob[1], dob[2]}, {16'h00FF, 16'h00FF, 16'h00FF});
      chk("t4_b_vld", {dob_vld[0], dob_vld[1], dob_vld[2]}, 3'b111);
      chk("t4_coll_rw", coll[0], 1'b1);

      // Write with no byte enables still produces a result but changes nothing.
      idle();
      wr_a(8'h30, 16'hFFFF, 2'b00);
      step();
      chk("t4_be0_m0", {doa[0], 15'b0, doa_vld[0]}, {16'h1234, 16'h0001});
      chk("t4_be0_m2_vld", doa_vld[2], 1'b0);
      idle();
      rd_b(8'h30);
      step();
      chk("t4_be0_nowrite", dob[0], 16'h1234);

      // Pipelined streaming through the OUT_REG=1 instance.
      idle();
      for (int i = 0; i < 8; i++) begin
         wr_a(8'(i), 16'h1000 + 16'(i) * 16'h0111, 2'b11);
         step();
      end
      idle();
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) rd_b(8'(k - 1));
         else enb = 1'b0;
         step();
         if (k == 1) begin
            chk("t5_lat1_reg_vld", dob_vld[3], 1'b0);
            chk("t5_lat1_dob", dob[0], 16'h1000);
         end else if (k <= 9) begin
            exp_d = 16'h1000 + 16'(k - 2) * 16'h0111;
            chk($sformatf("t5_stream_d%0d", k - 2), dob[3], exp_d);
            chk($sformatf("t5_stream_v%0d", k - 2), dob_vld[3], 1'b1);
         end else begin
            chk("t5_stream_end", dob_vld[3], 1'b0);
         end
      end

      // Reset in the middle of init restarts the sequence.
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) step();
      chk("t6_busy_mid", busy[0], 1'b1);
      rst_n = 1'b0;
      step();
      chk("t6_rst_outs", {doa[0], dob[0], dob[3]}, 48'h0);
      chk("t6_rst_flags", {doa_vld[0], dob_vld[0], dob_vld[3], coll[0]}, 4'b0);
      chk("t6_rst_busy", busy[0], 1'b1);
      rst_n = 1'b1;
      count_busy("init2", 256);
      rd_a(8'h30);
      rd_b(8'h10);
      step();
      chk("t6_reinit_a", doa[0], 16'h0000);
      chk("t6_reinit_b", dob[0], 16'h0000);
      chk("t6_reinit_vld", {doa_vld[0], dob_vld[0]}, 2'b11);
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
